// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer: drives one PE through a 2-D valid convolution and writes each psum out
module pe_conv_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 12,
    parameter int DIM_W      = 8,
    parameter int PE_LAT     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [2:0]              kernel_size_i,
    input  logic [DIM_W-1:0]        ifmap_w_i,
    input  logic [DIM_W-1:0]        ifmap_h_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    cfg_err_o,
    output logic                    pe_en_o,
    output logic                    pe_first_o,
    output logic [ADDR_W-1:0]       ifmap_addr_o,
    output logic [ADDR_W-1:0]       fltr_addr_o,
    input  logic [2*DATA_WIDTH-1:0] psum_in_i,
    output logic                    opsum_valid_o,
    input  logic                    opsum_ready_i,
    output logic [2*DATA_WIDTH-1:0] opsum_data_o,
    output logic [ADDR_W-1:0]       opsum_addr_o
);
    localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;
    state_t state_q, state_d;
    logic [2:0] k_q, k_d, kr_q, kr_d, kc_q, kc_d;
    logic [DIM_W-1:0] w_q, w_d, ow_q, ow_d, oh_q, oh_d, r_q, r_d, c_q, c_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [ADDR_W-1:0] rbase_q, rbase_d, wbase_q, wbase_d, lbase_q, lbase_d;
    logic [ADDR_W-1:0] ifmap_q, ifmap_d, fltr_q, fltr_d, oaddr_q, oaddr_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, pe_en_q, pe_en_d, first_q, first_d;
    logic valid_q, valid_d;
    logic [ADDR_W-1:0] w_ext;
    logic bad_cfg;
    assign w_ext   = ADDR_W'(w_q);
    assign bad_cfg = (kernel_size_i == 3'd0) || (DIM_W'(kernel_size_i) > ifmap_w_i)
                     || (DIM_W'(kernel_size_i) > ifmap_h_i);
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cfg_err_o     = err_q;
    assign pe_en_o       = pe_en_q;
    assign pe_first_o    = first_q;
    assign ifmap_addr_o  = ifmap_q;
    assign fltr_addr_o   = fltr_q;
    assign opsum_valid_o = valid_q;
    assign opsum_data_o  = data_q;
    assign opsum_addr_o  = oaddr_q;

    // Next state plus next output values; ifmap addresses are walked with row/line/window bases so no multiply is needed
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_d     = w_q;
        ow_d    = ow_q;
        oh_d    = oh_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        r_d     = r_q;
        c_d     = c_q;
        lat_d   = lat_q;
        rbase_d = rbase_q;
        wbase_d = wbase_q;
        lbase_d = lbase_q;
        ifmap_d = ifmap_q;
        fltr_d  = fltr_q;
        oaddr_d = oaddr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pe_en_d = 1'b0;
        first_d = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                k_d     = kernel_size_i;
                w_d     = ifmap_w_i;
                ow_d    = ifmap_w_i - DIM_W'(kernel_size_i) + DIM_W'(1);
                oh_d    = ifmap_h_i - DIM_W'(kernel_size_i) + DIM_W'(1);
                kr_d    = 3'd0;
                kc_d    = 3'd0;
                r_d     = '0;
                c_d     = '0;
                rbase_d = '0;
                wbase_d = '0;
                lbase_d = '0;
                ifmap_d = '0;
                fltr_d  = '0;
                oaddr_d = '0;
                if (bad_cfg) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_MAC;
                    busy_d  = 1'b1;
                    pe_en_d = 1'b1;
                    first_d = 1'b1;
                end
            end
            S_ERR: state_d = S_IDLE;
            S_MAC: if (kr_q == k_q - 3'd1 && kc_q == k_q - 3'd1) begin
                state_d = S_DRAIN;
                lat_d   = '0;
            end else begin
                pe_en_d = 1'b1;
                fltr_d  = fltr_q + ADDR_W'(1);
                if (kc_q == k_q - 3'd1) begin
                    kc_d    = 3'd0;
                    kr_d    = kr_q + 3'd1;
                    lbase_d = lbase_q + w_ext;
                    ifmap_d = lbase_q + w_ext;
                end else begin
                    kc_d    = kc_q + 3'd1;
                    ifmap_d = ifmap_q + ADDR_W'(1);
                end
            end
            S_DRAIN: if (lat_q == LW'(PE_LAT - 1)) begin
                state_d = S_WRITE;
                data_d  = psum_in_i;
                valid_d = 1'b1;
            end else begin
                lat_d = lat_q + LW'(1);
            end
            S_WRITE: if (opsum_ready_i) begin
                valid_d = 1'b0;
                if (c_q == ow_q - DIM_W'(1) && r_q == oh_q - DIM_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_MAC;
                    pe_en_d = 1'b1;
                    first_d = 1'b1;
                    kr_d    = 3'd0;
                    kc_d    = 3'd0;
                    fltr_d  = '0;
                    oaddr_d = oaddr_q + ADDR_W'(1);
                    if (c_q == ow_q - DIM_W'(1)) begin
                        c_d     = '0;
                        r_d     = r_q + DIM_W'(1);
                        rbase_d = rbase_q + w_ext;
                        wbase_d = rbase_q + w_ext;
                    end else begin
                        c_d     = c_q + DIM_W'(1);
                        wbase_d = wbase_q + ADDR_W'(1);
                    end
                    lbase_d = wbase_d;
                    ifmap_d = wbase_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; reset drops everything back to idle at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            w_q     <= '0;
            ow_q    <= '0;
            oh_q    <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            lat_q   <= '0;
            rbase_q <= '0;
            wbase_q <= '0;
            lbase_q <= '0;
            ifmap_q <= '0;
            fltr_q  <= '0;
            oaddr_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pe_en_q <= 1'b0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            ow_q    <= ow_d;
            oh_q    <= oh_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            r_q     <= r_d;
            c_q     <= c_d;
            lat_q   <= lat_d;
            rbase_q <= rbase_d;
            wbase_q <= wbase_d;
            lbase_q <= lbase_d;
            ifmap_q <= ifmap_d;
            fltr_q  <= fltr_d;
            oaddr_q <= oaddr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pe_en_q <= pe_en_d;
            first_q <= first_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_pe_conv_sequencer.sv
// tb_pe_conv_sequencer: random jobs against a loop-based convolution model with a behavioural PE
module tb_pe_conv_sequencer;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic rst, start;
    logic [2:0] ksz;
    logic [7:0] iw, ih;
    logic busy, done, cfg_err, pe_en, pe_first, opv;
    logic ordy = 1'b1;
    logic [11:0] ifa, fla, opa;
    logic [31:0] psum, opd;
    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [15:0] ifm [4096];
    logic [15:0] flt [4096];
    logic [31:0] acc = '0, p1 = '0, p2 = '0;

    typedef struct {int ia; int fa; int first; int cyc;} beat_t;
    typedef struct {int a; logic [31:0] d; int cyc;} wr_t;
    beat_t bq[$];
    wr_t wq[$];
    int epoch = 0, seen_epoch = 0, stall_req = 0, stalled = 0, stall_obs = 0;
    int err_pulses = 0, err_cyc = -1, busy_hi = 0, stab_err = 0, overlap = 0;
    bit rnd_ready = 0, hold_prev = 0;
    logic [11:0] pa;
    logic [31:0] pd;

    pe_conv_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start), .kernel_size_i(ksz),
        .ifmap_w_i(iw), .ifmap_h_i(ih), .busy_o(busy), .done_o(done),
        .cfg_err_o(cfg_err), .pe_en_o(pe_en), .pe_first_o(pe_first),
        .ifmap_addr_o(ifa), .fltr_addr_o(fla), .psum_in_i(psum),
        .opsum_valid_o(opv), .opsum_ready_i(ordy), .opsum_data_o(opd),
        .opsum_addr_o(opa)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PE stand-in: multiply-accumulate each beat, result appears LAT cycles after the last beat
    always @(posedge clk) begin
        if (pe_en) acc <= (pe_first ? 32'd0 : acc) + 32'(ifm[ifa]) * 32'(flt[fla]);
        p1 <= acc;
        p2 <= p1;
    end
    assign psum = p2;

    // Drives opsum_ready and records what the DUT did during the current job
    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            bq.delete();
            wq.delete();
            err_pulses = 0; err_cyc = -1; busy_hi = 0; stab_err = 0; overlap = 0;
            stalled = 0; stall_obs = 0; hold_prev = 0;
        end
        if (opv && stalled < stall_req) begin
            ordy = 1'b0;
            stalled++;
        end else begin
            ordy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (!rst) begin
            if (pe_en) bq.push_back('{int'(ifa), int'(fla), int'(pe_first), cyc});
            if (opv && ordy) wq.push_back('{int'(opa), opd, cyc});
            if (opv && !ordy) stall_obs++;
            if (cfg_err) begin err_pulses++; err_cyc = cyc; end
            if (busy) busy_hi++;
            if (pe_en && opv) overlap++;
            if (hold_prev && opv && (opa !== pa || opd !== pd)) stab_err++;
            hold_prev = opv && !ordy;
            pa = opa;
            pd = opd;
        end
    end

    task automatic test_reset();
        n_tests++;
        if ({busy, done, cfg_err, pe_en, pe_first, opv} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000000", {busy, done, cfg_err, pe_en, pe_first, opv});
        end
        n_tests++;
        if ({ifa, fla, opa, opd} !== 68'b0) begin
            n_fail++;
            $display("FAIL reset_buses got ifa=%0d fla=%0d opa=%0d opd=%0d exp all 0", ifa, fla, opa, opd);
        end
    endtask

    task automatic test_job(input int k, input int w, input int h, input int stall,
                            input bit rnd, input bit hold, input bit cont);
        int ow, oh, st, dc, bad, bi, exp_done;
        logic [31:0] sum;
        beat_t eb[$];
        wr_t ew[$];
        ow = w - k + 1;
        oh = h - k + 1;
        for (int i = 0; i < 4096; i++) begin
            ifm[i] = 16'($urandom_range(0, 255));
            flt[i] = 16'($urandom_range(0, 255));
        end
        epoch++;
        stall_req = stall;
        rnd_ready = rnd;
        if (!cont) begin
            @(posedge clk);
            #1;
        end
        ksz = 3'(k); iw = 8'(w); ih = 8'(h); start = 1'b1;
        st = cyc;
        if (!hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            ksz = 3'($urandom); iw = 8'($urandom); ih = 8'($urandom);
        end
        dc = -1;
        for (int i = 0; i < 20000 && dc < 0; i++) begin
            @(negedge clk);
            if (done) dc = cyc;
        end
        n_tests++;
        if (dc < 0) begin
            n_fail++;
            $display("FAIL done_timeout k=%0d w=%0d h=%0d got no done exp done", k, w, h);
            return;
        end
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                sum = '0;
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        eb.push_back('{((r + kr) * w + c + kc) % 4096, kr * k + kc, int'(kr == 0 && kc == 0), 0});
                        sum += 32'(ifm[(r + kr) * w + c + kc]) * 32'(flt[kr * k + kc]);
                    end
                ew.push_back('{r * ow + c, sum, 0});
            end
        exp_done = st + 1 + ow * oh * (k * k + LAT + 1) + stall_obs;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_done got %b exp 1", busy); end
        n_tests++;
        if (bq.size() != eb.size()) begin
            n_fail++;
            $display("FAIL beat_count k=%0d w=%0d h=%0d got %0d exp %0d", k, w, h, bq.size(), eb.size());
        end
        bad = 0; bi = -1;
        for (int i = 0; i < eb.size() && i < bq.size(); i++)
            if (bq[i].ia != eb[i].ia || bq[i].fa != eb[i].fa || bq[i].first != eb[i].first) begin
                bad++;
                if (bi < 0) bi = i;
            end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL beat_seq k=%0d w=%0d h=%0d idx %0d got ia=%0d fa=%0d first=%0d exp ia=%0d fa=%0d first=%0d",
                     k, w, h, bi, bq[bi].ia, bq[bi].fa, bq[bi].first, eb[bi].ia, eb[bi].fa, eb[bi].first);
        end
        if (bq.size() > 0) begin
            n_tests++;
            if (bq[0].cyc != st + 1) begin
                n_fail++;
                $display("FAIL first_beat_cycle got %0d exp %0d", bq[0].cyc, st + 1);
            end
        end
        n_tests++;
        if (wq.size() != ew.size()) begin
            n_fail++;
            $display("FAIL write_count k=%0d w=%0d h=%0d got %0d exp %0d", k, w, h, wq.size(), ew.size());
        end
        bad = 0; bi = -1;
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            if (wq[i].a != ew[i].a || wq[i].d !== ew[i].d) begin
                bad++;
                if (bi < 0) bi = i;
            end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL write_seq k=%0d w=%0d h=%0d idx %0d got addr=%0d data=%0d exp addr=%0d data=%0d",
                     k, w, h, bi, wq[bi].a, wq[bi].d, ew[bi].a, ew[bi].d);
        end
        n_tests++;
        if (dc != exp_done) begin
            n_fail++;
            $display("FAIL done_cycle k=%0d w=%0d h=%0d got %0d exp %0d", k, w, h, dc, exp_done);
        end
        n_tests++;
        if (stall_obs < stall) begin
            n_fail++;
            $display("FAIL stall_cycles got %0d exp at least %0d", stall_obs, stall);
        end
        n_tests++;
        if (overlap != 0 || stab_err != 0) begin
            n_fail++;
            $display("FAIL hold_rules got overlap=%0d unstable=%0d exp 0 0", overlap, stab_err);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_cfg_err(input int k, input int w, input int h);
        int st;
        epoch++;
        stall_req = 0;
        rnd_ready = 0;
        @(posedge clk);
        #1;
        ksz = 3'(k); iw = 8'(w); ih = 8'(h); start = 1'b1;
        st = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (err_pulses != 1 || err_cyc != st + 1) begin
            n_fail++;
            $display("FAIL cfg_err k=%0d w=%0d got pulses=%0d at %0d exp 1 at %0d", k, w, err_pulses, err_cyc, st + 1);
        end
        n_tests++;
        if (bq.size() != 0 || busy_hi != 0) begin
            n_fail++;
            $display("FAIL cfg_err_quiet k=%0d got beats=%0d busy_cycles=%0d exp 0 0", k, bq.size(), busy_hi);
        end
    endtask

    task automatic test_midjob_reset();
        int cnt;
        epoch++;
        stall_req = 0;
        rnd_ready = 0;
        @(posedge clk);
        #1;
        ksz = 3'd3; iw = 8'd5; ih = 8'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 12; i++) begin
            @(negedge clk);
            if (pe_en) cnt++;
        end
        n_tests++;
        if (cnt != 12) begin n_fail++; $display("FAIL midjob_beats got %0d exp 12", cnt); end
        rst = 1'b1;
        #1;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_job(3, 5, 5, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        test_job(2, 4, 3, 0, 0, 1, 0);
        test_job(3, 5, 4, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        int k, w, h;
        repeat (6) begin
            k = $urandom_range(1, 4);
            w = k + $urandom_range(0, 5);
            h = k + $urandom_range(0, 5);
            test_job(k, w, h, 0, 1, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ksz = '0; iw = '0; ih = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_job(3, 4, 4, 0, 0, 0, 0);
        test_job(1, 3, 2, 0, 0, 0, 0);
        test_job(3, 3, 3, 5, 0, 0, 0);
        test_cfg_err(0, 4, 4);
        test_cfg_err(5, 4, 8);
        test_midjob_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_conv_sequencer.md
# pe_conv_sequencer

Sequences a single processing element through a full 2-D valid convolution of one ifmap channel with one filter. It issues one MAC beat per cycle with ifmap/filter buffer addresses and drives the PE's external enable. It waits out the PE pipeline latency, then writes each finished psum to the output buffer through a valid/ready handshake. It sits between the host-side configuration registers and the PE, in external mode.

## Interface
- `DATA_WIDTH`, 16, PE operand width; psum width is 2*DATA_WIDTH
- `ADDR_W`, 12, width of all buffer addresses
- `DIM_W`, 8, width of ifmap width/height fields
- `PE_LAT`, 3, cycles from the last beat of a window to a valid `psum_in`
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a job; sampled only in IDLE
- `kernel_size`  in  3  K, legal 1..7; latched on start
- `ifmap_w`, `ifmap_h`  in  DIM_W each  ifmap dimensions; latched on start
- `busy`  out  1  high from the cycle after an accepted start until DONE exits
- `done`  out  1  one-cycle pulse at job end
- `cfg_err`  out  1  one-cycle pulse on an illegal config
- `pe_en`  out  1  MAC beat valid to the PE
- `pe_first`  out  1  with `pe_en`, marks the first beat of a window
- `ifmap_addr`  out  ADDR_W  ifmap buffer read address for this beat
- `fltr_addr`  out  ADDR_W  filter buffer read address for this beat
- `psum_in`  in  2*DATA_WIDTH  PE psum output
- `opsum_valid`  out  1  output write request
- `opsum_ready`  in  1  output buffer accepts
- `opsum_data`  out  2*DATA_WIDTH  captured psum
- `opsum_addr`  out  ADDR_W  output index, row-major

## Operation
- Output size: OW = W-K+1, OH = H-K+1. Window (r,c) has K*K beats (kr,kc), row-major.
- Beat addresses:
  - ifmap_addr = (r+kr)*W + (c+kc), built incrementally with adders only (no multiplier).
  - fltr_addr = kr*K + kc.
  - Both are truncated mod 2^ADDR_W.
- States:
  - IDLE: `start` latches the config. Go to ERR if K==0, K>W or K>H; otherwise go to MAC.
  - ERR: pulse `cfg_err`, return to IDLE. No beats are issued.
  - MAC: one beat per cycle with `pe_en`=1. After beat K*K-1, go to DRAIN.
  - DRAIN: count PE_LAT cycles. On the last one, capture `psum_in` into `opsum_data` and go to WRITE.
  - WRITE: hold `opsum_valid` until `opsum_ready`. On acceptance, advance c; when c wraps, advance r. Go to MAC for the next window, or to DONE after window (OH-1,OW-1).
  - DONE: pulse `done`, return to IDLE.
- A `start` asserted outside IDLE is ignored.
- Config inputs are don't-care after latch.
- `opsum_addr` = r*OW + c, held stable while `opsum_valid` is high.
- `opsum_data` and `opsum_addr` must not change while `opsum_valid`=1 and `opsum_ready`=0.
- The PE sees exactly K*K `pe_en` beats per window, the first with `pe_first`.
- Reset mid-job: all state returns to IDLE immediately; any in-flight psum is discarded.

## Timing
- Reset values:
  - `busy`, `done`, `cfg_err`, `pe_en`, `pe_first`, `opsum_valid`: 0.
  - `ifmap_addr`, `fltr_addr`, `opsum_addr`, `opsum_data`: 0.
- All outputs are registered.
- Start accepted at edge t: first beat visible in cycle t+1.
- Per window with `opsum_ready` tied high: K*K (MAC) + PE_LAT (DRAIN) + 1 (WRITE) cycles.
- Job cycles with `opsum_ready`=1: OW*OH*(K*K+PE_LAT+1), then `done` in the next cycle.
- `busy` drops the cycle after `done`. A new `start` can be accepted in that same cycle.
- `pe_en` is 0 in DRAIN and WRITE; no beats are issued while stalled.
- `cfg_err` fires the cycle after `start`; `busy` stays 0 for an errored job.

## Test plan
- K=3, W=H=4, ready=1:
  - First window ifmap_addr 0,1,2,4,5,6,8,9,10 and fltr_addr 0..8.
  - `pe_first` on beat 0 only.
  - 4 writes to opsum_addr 0,1,2,3.
  - `done` 52 cycles after the first beat.
- K=1, W=3, H=2: 6 single-beat windows; ifmap_addr equals opsum_addr 0..5; `pe_first` on every beat.
- K=3, W=H=3, `opsum_ready` low for 5 cycles in WRITE:
  - `opsum_valid`, `opsum_data` and `opsum_addr`=0 held stable.
  - `pe_en` stays 0 throughout.
  - `done` arrives 5 cycles later than the unstalled case.
- K=0, then K=5 with W=4: each gives one `cfg_err` pulse, no `pe_en`, and `busy` stays 0.
- `rst` asserted during the 3rd beat of window 2: all outputs are 0 immediately; a fresh start then runs cleanly from opsum_addr 0.
- `start` held high during the whole job: exactly one job runs. A re-start in the cycle after `done` begins a second job with correct addresses.
